// File: rtl/win_spill_fill.sv
// win_spill_fill: register-window spill/fill controller for the p18240 windowed register file.
// Optional build macro WIN_SPILL_STATS_EN adds saturating spill/fill window counters.
module win_spill_fill #(
   parameter int unsigned NWIN        = 7,
   parameter logic [15:0] SPILL_BASE  = 16'hF000,
   parameter int unsigned SPILL_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset_L,
   input  logic        save_req,
   input  logic        restore_req,
   output logic        busy,
   output logic [1:0]  winAddSub,
   output logic [4:0]  rf_sel,
   input  logic [15:0] rf_rdata,
   output logic [15:0] rf_wdata,
   output logic        rf_load_L,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic        win_err,
   output logic [15:0] spill_cnt,
   output logic [15:0] fill_cnt
);

   localparam int unsigned RES_W = $clog2(NWIN + 1);
   localparam int unsigned SP_W  = $clog2(SPILL_WORDS + 1);
   localparam logic [RES_W-1:0] RES_MAX = RES_W'(NWIN);
   localparam logic [RES_W-1:0] RES_ONE = RES_W'(1);
   localparam logic [SP_W-1:0]  SP_MAX  = SP_W'(SPILL_WORDS);
   localparam logic [SP_W-1:0]  SP_WIN  = SP_W'(4);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SPILL_REQ = 3'd1,
      FILL_REQ  = 3'd2,
      FILL_WR   = 3'd3,
      SHIFT     = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        k_q, k_d, k_inc;
   logic [4:0]        cwp_q, cwp_d;
   logic [4:0]        oldest_q, oldest_d;
   logic [RES_W-1:0]  res_q, res_d;
   logic [SP_W-1:0]   sp_q, sp_d, sp_dec;
   logic              shift_add_q, shift_add_d;
   logic              busy_d, win_err_d, rf_load_l_d, mem_req_d, mem_we_d;
   logic [1:0]        win_add_sub_d;
   logic [4:0]        rf_sel_d;
   logic [15:0]       rf_wdata_d, mem_addr_d;
   logic              spill_done, fill_done;

   assign k_inc  = k_q + 2'd1;
   assign sp_dec = sp_q - SP_WIN;

   // Spill data comes straight from the register file read port at rf_sel
   assign mem_wdata = (mem_req && mem_we) ? rf_rdata : 16'h0000;

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      cwp_d         = cwp_q;
      oldest_d      = oldest_q;
      res_d         = res_q;
      sp_d          = sp_q;
      shift_add_d   = shift_add_q;
      busy_d        = busy;
      win_add_sub_d = 2'b00;
      rf_sel_d      = rf_sel;
      rf_wdata_d    = rf_wdata;
      rf_load_l_d   = 1'b1;
      mem_req_d     = mem_req;
      mem_we_d      = mem_we;
      mem_addr_d    = mem_addr;
      win_err_d     = 1'b0;
      spill_done    = 1'b0;
      fill_done     = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (save_req && !restore_req) begin
               if (res_q < RES_MAX) begin
                  state_d       = SHIFT;
                  shift_add_d   = 1'b1;
                  busy_d        = 1'b1;
                  win_add_sub_d = 2'b10;
               end else if (sp_q == SP_MAX) begin
                  win_err_d = 1'b1;
               end else begin
                  state_d    = SPILL_REQ;
                  k_d        = 2'd0;
                  busy_d     = 1'b1;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b1;
                  mem_addr_d = SPILL_BASE + 16'(sp_q);
                  rf_sel_d   = oldest_q;
               end
            end else if (restore_req && !save_req) begin
               if (res_q > RES_ONE) begin
                  state_d       = SHIFT;
                  shift_add_d   = 1'b0;
                  busy_d        = 1'b1;
                  win_add_sub_d = 2'b01;
               end else if (sp_q == '0) begin
                  win_err_d = 1'b1;
               end else begin
                  state_d    = FILL_REQ;
                  sp_d       = sp_dec;
                  oldest_d   = oldest_q - 5'd4;
                  k_d        = 2'd0;
                  busy_d     = 1'b1;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = SPILL_BASE + 16'(sp_dec);
               end
            end
         end

         SPILL_REQ: begin
            if (mem_ack) begin
               if (k_q != 2'd3) begin
                  k_d        = k_inc;
                  mem_addr_d = SPILL_BASE + 16'(sp_q) + 16'(k_inc);
                  rf_sel_d   = oldest_q + 5'(k_inc);
               end else begin
                  // Oldest window now lives in memory; the shift re-counts it as the new window
                  sp_d          = sp_q + SP_WIN;
                  oldest_d      = oldest_q + 5'd4;
                  res_d         = res_q - RES_ONE;
                  mem_req_d     = 1'b0;
                  mem_we_d      = 1'b0;
                  state_d       = SHIFT;
                  shift_add_d   = 1'b1;
                  win_add_sub_d = 2'b10;
                  spill_done    = 1'b1;
               end
            end
         end

         FILL_REQ: begin
            if (mem_ack) begin
               state_d     = FILL_WR;
               mem_req_d   = 1'b0;
               rf_wdata_d  = mem_rdata;
               rf_sel_d    = oldest_q + 5'(k_q);
               rf_load_l_d = 1'b0;
            end
         end

         FILL_WR: begin
            if (k_q != 2'd3) begin
               state_d    = FILL_REQ;
               k_d        = k_inc;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = SPILL_BASE + 16'(sp_q) + 16'(k_inc);
            end else begin
               state_d       = SHIFT;
               res_d         = res_q + RES_ONE;
               shift_add_d   = 1'b0;
               win_add_sub_d = 2'b01;
               fill_done     = 1'b1;
            end
         end

         SHIFT: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (shift_add_q) begin
               cwp_d = cwp_q + 5'd4;
               res_d = res_q + RES_ONE;
            end else begin
               cwp_d = cwp_q - 5'd4;
               res_d = res_q - RES_ONE;
            end
         end

         default: begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= IDLE;
         k_q         <= 2'd0;
         cwp_q       <= 5'd0;
         oldest_q    <= 5'd0;
         res_q       <= RES_ONE;
         sp_q        <= '0;
         shift_add_q <= 1'b0;
         busy        <= 1'b0;
         winAddSub   <= 2'b00;
         rf_sel      <= 5'd0;
         rf_wdata    <= 16'h0000;
         rf_load_L   <= 1'b1;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 16'h0000;
         win_err     <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         cwp_q       <= cwp_d;
         oldest_q    <= oldest_d;
         res_q       <= res_d;
         sp_q        <= sp_d;
         shift_add_q <= shift_add_d;
         busy        <= busy_d;
         winAddSub   <= win_add_sub_d;
         rf_sel      <= rf_sel_d;
         rf_wdata    <= rf_wdata_d;
         rf_load_L   <= rf_load_l_d;
         mem_req     <= mem_req_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         win_err     <= win_err_d;
      end
   end

`ifdef WIN_SPILL_STATS_EN
   // Saturating completed-window counters
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         spill_cnt <= 16'h0000;
         fill_cnt  <= 16'h0000;
      end else begin
         if (spill_done && (spill_cnt != 16'hFFFF)) spill_cnt <= spill_cnt + 16'd1;
         if (fill_done && (fill_cnt != 16'hFFFF))   fill_cnt  <= fill_cnt + 16'd1;
      end
   end
`else
   logic unused_stats;
   assign unused_stats = spill_done | fill_done;
   assign spill_cnt    = 16'h0000;
   assign fill_cnt     = 16'h0000;
`endif

endmodule
